// File: rtl/aes_pkg.sv
// Shared AES constants and byte-index tables for the byte-serial datapath.
// The encrypt path uses shift_rows_idx; the inverse table serves the decrypt path.
package aes_pkg;

    localparam int AES_BLOCK_BYTES = 16;
    localparam int AES_BYTE_W      = 8;

    typedef logic [AES_BYTE_W-1:0] aes_byte_t;
    typedef logic [3:0]            aes_idx_t;

    localparam aes_idx_t AES_LAST_IDX = aes_idx_t'(AES_BLOCK_BYTES - 1);

    // Stream position (sel, cnt) of one side of the ping-pong buffer pair.
    typedef struct packed {
        logic     sel;
        aes_idx_t cnt;
    } buf_ptr_t;

    // Output byte j takes input byte SHIFT_ROWS_PERM[j] (column-major, i = 4c + r).
    localparam aes_idx_t SHIFT_ROWS_PERM [AES_BLOCK_BYTES] = '{
        4'd0, 4'd5, 4'd10, 4'd15, 4'd4, 4'd9, 4'd14, 4'd3,
        4'd8, 4'd13, 4'd2, 4'd7, 4'd12, 4'd1, 4'd6, 4'd11
    };

    localparam aes_idx_t INV_SHIFT_ROWS_PERM [AES_BLOCK_BYTES] = '{
        4'd0, 4'd13, 4'd10, 4'd7, 4'd4, 4'd1, 4'd14, 4'd11,
        4'd8, 4'd5, 4'd2, 4'd15, 4'd12, 4'd9, 4'd6, 4'd3
    };

    function automatic aes_idx_t shift_rows_idx(input aes_idx_t j);
        return SHIFT_ROWS_PERM[j];
    endfunction

    function automatic aes_idx_t inv_shift_rows_idx(input aes_idx_t j);
        return INV_SHIFT_ROWS_PERM[j];
    endfunction

endpackage

// File: rtl/shift_rows_serial_if.sv
// Byte-stream in/out handshake bundle for the serial ShiftRows stage.
// slave is the block side; master is the upstream/downstream side.
interface shift_rows_serial_if;
    import aes_pkg::*;

    logic      in_valid;
    logic      in_ready;
    aes_byte_t in_data;
    logic      out_valid;
    logic      out_ready;
    aes_byte_t out_data;
    logic      out_last;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

endinterface

// File: rtl/aes_byte_buf.sv
// 16x8 register buffer: one synchronous write port, one asynchronous read port.
module aes_byte_buf
    import aes_pkg::*;
(
    input  logic      clk,
    input  logic      we_i,
    input  aes_idx_t  waddr_i,
    input  aes_byte_t wdata_i,
    input  aes_idx_t  raddr_i,
    output aes_byte_t rdata_o
);

    aes_byte_t mem_q [AES_BLOCK_BYTES];

    // NOTE: storage has no reset; the owner's full flags decide when contents are meaningful.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/shift_rows_serial.sv
// Byte-serial AES ShiftRows: ping-pong pair of 16-byte buffers, written in input
// order and read back through the ShiftRows index table.
module shift_rows_serial
    import aes_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    shift_rows_serial_if.slave  bus
);

    logic [1:0] full_q, full_d;
    buf_ptr_t   wr_q, wr_d;
    buf_ptr_t   rd_q, rd_d;

    logic      in_fire;
    logic      out_fire;
    aes_idx_t  raddr;
    aes_byte_t rdata [2];

    // Gating with rst keeps both handshakes quiet while the pointers are being cleared.
    always_comb begin
        bus.in_ready  = !rst && !full_q[wr_q.sel];
        bus.out_valid = !rst && full_q[rd_q.sel];
        bus.out_data  = bus.out_valid ? rdata[rd_q.sel] : '0;
        bus.out_last  = bus.out_valid && (rd_q.cnt == AES_LAST_IDX);
    end

    assign in_fire  = bus.in_valid && bus.in_ready;
    assign out_fire = bus.out_valid && bus.out_ready;
    assign raddr    = shift_rows_idx(rd_q.cnt);

    for (genvar g = 0; g < 2; g++) begin : gen_buf
        aes_byte_buf u_buf (
            .clk     (clk),
            .we_i    (in_fire && (wr_q.sel == 1'(g))),
            .waddr_i (wr_q.cnt),
            .wdata_i (bus.in_data),
            .raddr_i (raddr),
            .rdata_o (rdata[g])
        );
    end

    // Write and read always target different buffers, so both flag updates can land together.
    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latch).
        full_d = full_q;
        wr_d   = wr_q;
        rd_d   = rd_q;

        if (in_fire) begin
            if (wr_q.cnt == AES_LAST_IDX) begin
                full_d[wr_q.sel] = 1'b1;
                wr_d.sel         = ~wr_q.sel;
                wr_d.cnt         = '0;
            end else begin
                wr_d.cnt = wr_q.cnt + 4'd1;
            end
        end

        if (out_fire) begin
            if (rd_q.cnt == AES_LAST_IDX) begin
                full_d[rd_q.sel] = 1'b0;
                rd_d.sel         = ~rd_q.sel;
                rd_d.cnt         = '0;
            end else begin
                rd_d.cnt = rd_q.cnt + 4'd1;
            end
        end
    end

    // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            full_q <= '0;
            wr_q   <= '0;
            rd_q   <= '0;
        end else begin
            full_q <= full_d;
            wr_q   <= wr_d;
            rd_q   <= rd_d;
        end
    end

endmodule

// File: tb/tb_shift_rows_serial.sv
// Randomized bench for shift_rows_serial against a ShiftRows rule model with
// per-byte ordering, handshake stability, backpressure, latency and reset checks.
module tb_shift_rows_serial;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    shift_rows_serial_if bus ();

    shift_rows_serial dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    byte unsigned src_q [$];
    byte unsigned acc_q [$];
    byte unsigned exp_q [$];
    byte unsigned got_q [$];

    int out_idx = 0;
    int cyc     = 0;
    int p_in    = 100;
    int p_out   = 100;

    int n_acc, n_rd, blk_done_cyc, first_ov_cyc, last_rd_cyc, ir_dropped, ir_return_rd;
    bit ir_low_seen;

    bit         prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;
    logic       prev_last  = 1'b0;

    byte unsigned vec1 [16] = '{8'h00, 8'h05, 8'h0a, 8'h0f, 8'h04, 8'h09, 8'h0e, 8'h03,
                                8'h08, 8'h0d, 8'h02, 8'h07, 8'h0c, 8'h01, 8'h06, 8'h0b};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ShiftRows rule: output position j = 4c + r takes s(r, (c + r) mod 4).
    function automatic int sr_src(input int j);
        int c = j / 4;
        int r = j % 4;
        return 4 * ((c + r) % 4) + r;
    endfunction

    task automatic reset_stats();
        n_acc        = 0;
        n_rd         = 0;
        blk_done_cyc = -1;
        first_ov_cyc = -1;
        last_rd_cyc  = -1;
        ir_dropped   = 0;
        ir_return_rd = -1;
        ir_low_seen  = 1'b0;
        got_q.delete();
    endtask

    task automatic push_seq(input int base, input int len);
        for (int i = 0; i < len; i++) src_q.push_back(byte'(base + i));
    endtask

    task automatic push_rand(input int len);
        for (int i = 0; i < len; i++) src_q.push_back(byte'($urandom));
    endtask

    // Called at the falling edge: checks outputs, then books the handshakes of the coming edge.
    task automatic sample();
        bit in_fire;
        bit out_fire;
        if (prev_stall) begin
            check("hold_data", bus.out_data, prev_data);
            check("hold_last", bus.out_last, prev_last);
        end
        if (bus.out_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_valid", bus.out_valid, 1'b0);
            end else begin
                check("out_data", bus.out_data, exp_q[0]);
                check("out_last", bus.out_last, out_idx == 15);
            end
            if (first_ov_cyc < 0) first_ov_cyc = cyc;
        end else begin
            check("idle_out", {bus.out_last, bus.out_data}, 9'h000);
        end

        if (!bus.in_ready) ir_low_seen = 1'b1;
        else if (ir_low_seen && ir_return_rd < 0) ir_return_rd = n_rd;
        if (bus.in_valid && !bus.in_ready) ir_dropped++;

        in_fire  = bus.in_valid && bus.in_ready;
        out_fire = bus.out_valid && bus.out_ready;

        if (out_fire && exp_q.size() > 0) begin
            got_q.push_back(bus.out_data);
            void'(exp_q.pop_front());
            out_idx     = (out_idx + 1) % 16;
            n_rd++;
            last_rd_cyc = cyc;
        end
        if (in_fire) begin
            acc_q.push_back(src_q.pop_front());
            n_acc++;
            if (acc_q.size() == 16) begin
                for (int j = 0; j < 16; j++) exp_q.push_back(acc_q[sr_src(j)]);
                acc_q.delete();
                if (blk_done_cyc < 0) blk_done_cyc = cyc;
            end
        end

        prev_stall = bus.out_valid && !bus.out_ready;
        prev_data  = bus.out_data;
        prev_last  = bus.out_last;
    endtask

    // mode 0: run the full budget; 1: until all sent and drained; 2: until all sent.
    task automatic run(input int budget, input int mode);
        bit done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (mode == 1 && src_q.size() == 0 && exp_q.size() == 0) begin done = 1'b1; break; end
            if (mode == 2 && src_q.size() == 0) begin done = 1'b1; break; end
            bus.in_valid = (src_q.size() > 0) && ($urandom_range(0, 99) < p_in);
            if (bus.in_valid) bus.in_data = src_q[0];
            else              bus.in_data = 8'h00;
            bus.out_ready = $urandom_range(0, 99) < p_out;
            @(negedge clk);
            sample();
            cyc++;
            @(posedge clk);
            #1;
        end
        if (mode == 1 && src_q.size() == 0 && exp_q.size() == 0) done = 1'b1;
        if (mode == 2 && src_q.size() == 0) done = 1'b1;
        if (mode != 0) check("run_done", done, 1'b1);
    endtask

    task automatic do_reset();
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b0;
        rst           = 1'b1;
        @(negedge clk);
        check("rst_in_ready", bus.in_ready, 1'b0);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out", {bus.out_last, bus.out_data}, 9'h000);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", bus.in_ready, 1'b1);
        check("post_rst_out_valid", bus.out_valid, 1'b0);
        check("post_rst_out", {bus.out_last, bus.out_data}, 9'h000);
        @(posedge clk);
        #1;
        src_q.delete();
        acc_q.delete();
        exp_q.delete();
        out_idx    = 0;
        prev_stall = 1'b0;
    endtask

    task automatic check_vec1(input string tag);
        check({tag, "_count"}, got_q.size(), 16);
        for (int j = 0; j < 16 && j < got_q.size(); j++) check(tag, got_q[j], vec1[j]);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Single block, full throughput, latency of one cycle after the 16th accept.
        reset_stats();
        p_in = 100; p_out = 100;
        push_seq(8'h00, 16);
        run(200, 1);
        check("latency", first_ov_cyc - blk_done_cyc, 1);
        check_vec1("vec1");

        // Two back-to-back blocks: no input stall, 32 contiguous outputs.
        reset_stats();
        push_seq(8'h00, 32);
        run(200, 1);
        check("b2b_in_ready_drops", ir_dropped, 0);
        check("b2b_contiguous", last_rd_cyc - first_ov_cyc, 31);
        check("b2b_blk2_b0", (got_q.size() > 16) ? got_q[16] : 8'hxx, 8'h10);
        check("b2b_blk2_b1", (got_q.size() > 17) ? got_q[17] : 8'hxx, 8'h15);
        check("b2b_blk2_b7", (got_q.size() > 23) ? got_q[23] : 8'hxx, 8'h13);

        // Backpressure: absorb exactly 32 bytes, free up after 16 reads.
        reset_stats();
        p_out = 0;
        push_rand(48);
        run(60, 0);
        check("bp_accepted", n_acc, 32);
        check("bp_in_ready", bus.in_ready, 1'b0);
        reset_stats();
        p_out = 100;
        run(300, 1);
        check("bp_ready_after_reads", ir_return_rd, 16);
        check("bp_drained", n_rd, 48);

        // Random gaps over 200 random blocks.
        for (int k = 0; k < 4; k++) begin
            case (k)
                0: begin p_in = 70; p_out = 60; end
                1: begin p_in = 40; p_out = 90; end
                2: begin p_in = 95; p_out = 30; end
                default: begin p_in = $urandom_range(20, 100); p_out = $urandom_range(20, 100); end
            endcase
            reset_stats();
            push_rand(50 * 16);
            run(20000, 1);
            check("rand_drained", n_rd, 50 * 16);
        end

        // Reset mid-block.
        p_in = 100; p_out = 100;
        push_rand(7);
        run(100, 2);
        do_reset();
        reset_stats();
        push_seq(8'h00, 16);
        run(200, 1);
        check_vec1("rst_partial_vec1");

        // Reset while one buffer is full and the other partly written.
        p_out = 0;
        push_rand(20);
        run(100, 2);
        check("full_before_rst", bus.out_valid, 1'b1);
        do_reset();
        reset_stats();
        p_out = 100;
        push_seq(8'h00, 16);
        run(200, 1);
        check_vec1("rst_full_vec1");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/shift_rows_serial.md
Name: shift_rows_serial

Overview:
- Byte-serial AES ShiftRows stage for the encrypt datapath.
- Accepts one 16-byte AES state as a byte stream with a valid/ready handshake.
- Emits the ShiftRows-permuted state as a byte stream, also with valid/ready.
- Sits between the SPI byte front-end and the byte-serial encrypt round logic; it is the forward counterpart of the team's combinational inverse ShiftRows.

Parameters:
- None. Byte width is 8 and block size is 16 bytes, both fixed by AES.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  in_data holds a valid state byte
- in_ready  output  1  block can accept a byte this cycle
- in_data  input  8  state byte, input order b0..b15
- out_valid  output  1  out_data holds a valid permuted byte
- out_ready  input  1  downstream accepts out_data this cycle
- out_data  output  8  permuted state byte
- out_last  output  1  marks the 16th output byte of a block

Behaviour:
- State byte layout (FIPS-197): byte i maps to s(r,c) with i = 4c + r. Input and output streams are column-major, b0 first.
- ShiftRows rule: s'(r,c) = s(r,(c+r) mod 4).
- Output byte j = input byte PERM[j]. PERM = 0,5,10,15,4,9,14,3,8,13,2,7,12,1,6,11.
- Storage: two 16x8 register buffers in ping-pong, each with a full flag.
- Write side: wr_sel (1b), wr_cnt (4b).
  - in_ready = !rst && !full[wr_sel].
  - A transfer (in_valid && in_ready) writes buf[wr_sel][wr_cnt] and increments wr_cnt.
  - On wr_cnt==15: set full[wr_sel], toggle wr_sel, clear wr_cnt.
- Read side: rd_sel (1b), rd_cnt (4b).
  - out_valid = full[rd_sel].
  - out_data = buf[rd_sel][PERM[rd_cnt]] when out_valid, else 8'h00.
  - out_last = out_valid && rd_cnt==15.
  - A transfer (out_valid && out_ready) increments rd_cnt.
  - On rd_cnt==15: clear full[rd_sel], toggle rd_sel, clear rd_cnt.
- Per-buffer states: EMPTY/FILLING → FULL (16th write) → DRAINING → EMPTY (16th read). A buffer is never written while full and never read while not full.
- Latency: if the 16th byte is accepted at edge N, out_valid is high from cycle N+1 with out_data = input byte 0.
- Throughput: 1 byte/cycle sustained when in_valid and out_ready are held high. in_ready never drops in that case.
- Backpressure:
  - With out_ready low, the block absorbs exactly 32 bytes, then in_ready deasserts.
  - in_ready reasserts the cycle after the 16th read of the draining buffer.
- Stability: while out_valid && !out_ready, out_data and out_last hold their values.
- Simultaneous events:
  - Completing a write on one buffer and completing a read on the other in the same cycle are independent.
  - Both flag updates take effect at that edge.
- Input protocol: no in_last. Block boundaries come only from the 16-byte count.
- Reset:
  - Clears full[1:0], wr_sel, wr_cnt, rd_sel, rd_cnt. Buffer contents are not reset.
  - Output values while rst is high and in the first cycle after: in_ready=0 during rst and 1 afterwards; out_valid=0; out_data=8'h00; out_last=0.
  - Reset mid-block discards any partial or full blocks. The first byte after reset is treated as byte 0.

Decomposition:
- Shared package aes_pkg:
  - AES_BLOCK_BYTES=16
  - AES_BYTE_W=8
  - SHIFT_ROWS_PERM and INV_SHIFT_ROWS_PERM index tables, with functions shift_rows_idx(j) and inv_shift_rows_idx(j).
- One sub-module: aes_byte_buf, a 16x8 register buffer with write port (we, waddr, wdata) and asynchronous read port (raddr, rdata). Instantiated twice.

Test Plan:
1. Feed bytes 00..0f contiguously with out_ready=1 → output 00 05 0a 0f 04 09 0e 03 08 0d 02 07 0c 01 06 0b. out_valid rises the cycle after the 16th accept; out_last is high only on 0b.
2. Feed two blocks, 00..0f then 10..1f, back-to-back with out_ready=1 → in_ready stays 1 throughout. 32 contiguous output bytes; the second block starts 10 15 1a 1f 14 19 1e 13.
3. Hold out_ready=0 and offer 48 bytes → exactly 32 are accepted, then in_ready=0. Raise out_ready → in_ready returns after 16 reads, and all three blocks come out in order and correctly permuted.
4. Drive random in_valid/out_ready gaps over 200 random blocks → output matches the PERM model. out_data and out_last stay stable whenever out_valid && !out_ready.
5. Assert rst after 7 bytes of block A, and separately while one buffer is full → the cycle after release shows out_valid=0, in_ready=1, out_data=00. The next block 00..0f then produces the vector from scenario 1.
